block_transfer_sequencer: RTL
=============================

# block_transfer_sequencer

Multi-cycle sequencer for ARM LDM/STM (block data transfer) instructions. The register-addressing decode supplies only the base register (Rn) for this class, so this block takes the 16-bit register list and emits register numbers and word addresses one beat at a time toward the load/store unit. It also produces the base writeback value. It sits between decode and the memory interface and stalls the pipeline while a transfer is in flight.

## Interface
- No parameters; data width fixed at 32, register index width fixed at 4.
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  launch request; sampled only in IDLE
- instruction  in  28  instruction[27:0]; uses P=[24], U=[23], W=[21], L=[20], list=[15:0]
- base  in  32  current value of Rn (instruction[19:16]), sampled with start
- ready  in  1  memory side accepts the current beat
- busy  out  1  high from the cycle after start is accepted until done clears; pipeline stall
- valid  out  1  a beat (reg_addr, mem_addr) is presented
- reg_addr  out  4  register number of the current beat
- mem_addr  out  32  word address of the current beat, bits [1:0] always 0
- load  out  1  registered copy of L for the operation
- last  out  1  current beat is the final beat
- done  out  1  one-cycle pulse at operation end
- wb_en  out  1  with done: write wb_value to Rn (registered W)
- wb_value  out  32  base ± 4·n, valid while done

## Operation
- States: IDLE, XFER, DONE.
- IDLE: start=1 latches list, P, U, W, L and base[31:2]:00. It also computes n = popcount(list), range 0..16.
  - If n=0, next state is DONE; otherwise XFER.
- Start address by mode, with all arithmetic mod 2^32:
  - IA (P=0,U=1): base
  - IB (P=1,U=1): base+4
  - DA (P=0,U=0): base−4n+4
  - DB (P=1,U=0): base−4n
- wb_value: U=1 gives base+4n; U=0 gives base−4n. For n=0, wb_value = base.
- XFER behaviour:
  - valid=1.
  - reg_addr = index of the lowest set bit of the remaining list.
  - last=1 when exactly one bit remains.
- Beat acceptance (valid & ready):
  - Clear that bit; mem_addr += 4.
  - If last, go to DONE.
- Registers always go out in ascending order at ascending addresses, regardless of U.
- DONE: done=1 and wb_en=W for exactly one cycle, then IDLE.
- start is ignored while busy=1 or in DONE; there is no queueing.
- ready while valid=0 has no effect.
- reset in any state returns to IDLE at the next edge, discarding the transfer and producing no done.

## Timing
- Reset values: busy=0, valid=0, reg_addr=0, mem_addr=0, load=0, last=0, done=0, wb_en=0, wb_value=0.
- start accepted at edge T: busy=1 and the first beat is valid after T; there are no bubbles between beats when ready is held high.
- n beats with ready always high: done is asserted in cycle T+n+1, and busy drops after it.
- Stalls: valid, reg_addr, mem_addr and last hold stable while ready=0.
- Empty list: done is asserted in the cycle after the start edge, with no beats.
- busy=1 in XFER and DONE.
- All outputs are registered.

## Structure
- Shared package (core defines): mode encodings IA/IB/DA/DB and instruction bit positions P/U/W/L. This is the same location as the other decode field constants.
- One natural sub-module, priority_bit_find: combinational 16-bit lowest-set-bit index plus a "one bit remaining" flag. It is reusable by the register-file writeback path.
- popcount is inline in the top-level module.

## Test plan
- STMIA, list=0x000F, base=0x1000, ready=1 → beats r0..r3 at 0x1000/4/8/C; last on r3; done at T+5; wb_value=0x1010.
- LDMDB, list=0x8006, base=0x2000, W=1 → r1@0x1FF4, r2@0x1FF8, r15@0x1FFC; load=1; wb_en=1, wb_value=0x1FF4.
- LDMIB, list=0x0001, base=0xFFFFFFFC, with ready low for 3 cycles → r0@0x00000000 (wrap), held stable through the stall; last on the first beat.
- Empty list, STMDA, base=0x3000 → no valid; done in the cycle after start; wb_value=0x3000.
- Second start pulsed mid-transfer → ignored; first operation completes unchanged; exactly one done.
- reset asserted on the 2nd beat of list=0xFFFF → all outputs at reset values next cycle; no done; new start then runs normally.

Source files
------------

// File: rtl/block_transfer_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// block_transfer_sequencer_pkg
// Shared core defines for the LDM/STM block-transfer path: instruction field
// bit positions, addressing-mode encodings, sequencer states and the address
// helpers used to derive the first beat address and the base writeback value.
// ---------------------------------------------------------------------------
package block_transfer_sequencer_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 4;
    localparam int LIST_W = 16;
    localparam int CNT_W  = 5;   // popcount of a 16-bit list spans 0..16

    // Instruction field positions within instruction[27:0]
    localparam int INSTR_P_BIT    = 24;
    localparam int INSTR_U_BIT    = 23;
    localparam int INSTR_W_BIT    = 21;
    localparam int INSTR_L_BIT    = 20;
    localparam int INSTR_LIST_LSB = 0;

    // Addressing modes, encoded as {P, U}
    typedef enum logic [1:0] {
        MODE_DA = 2'b00,
        MODE_IA = 2'b01,
        MODE_DB = 2'b10,
        MODE_IB = 2'b11
    } xfer_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_DONE = 2'b10
    } seq_state_e;

    // Lowest beat address. Beats always ascend from here, so descending
    // modes start below the base by the full transfer span.
    function automatic logic [DATA_W-1:0] first_addr(
        input xfer_mode_e        mode,
        input logic [DATA_W-1:0] base,
        input logic [DATA_W-1:0] span
    );
        logic [DATA_W-1:0] addr;
        case (mode)
            MODE_IA: addr = base;
            MODE_IB: addr = base + 32'd4;
            MODE_DA: addr = base - span + 32'd4;
            MODE_DB: addr = base - span;
            default: addr = base;
        endcase
        return addr;
    endfunction

    function automatic logic [DATA_W-1:0] wb_addr(
        input logic              up,
        input logic [DATA_W-1:0] base,
        input logic [DATA_W-1:0] span
    );
        return up ? (base + span) : (base - span);
    endfunction

endpackage

// File: rtl/block_transfer_sequencer_priority_bit_find.sv
// ---------------------------------------------------------------------------
// priority_bit_find
// Combinational lowest-set-bit finder for a 16-bit register list.
//   vec_i  in  16  register list
//   idx_o  out  4  index of the lowest set bit (0 when vec_i is zero)
//   one_o  out  1  exactly one bit of vec_i is set
// ---------------------------------------------------------------------------
module priority_bit_find
    import block_transfer_sequencer_pkg::*;
(
    input  logic [LIST_W-1:0] vec_i,
    output logic [REG_W-1:0]  idx_o,
    output logic              one_o
);

    // Scan from the top so the lowest set bit is the last to write idx_o.
    always_comb begin
        idx_o = '0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = REG_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    assign one_o = (vec_i != '0) && ((vec_i & (vec_i - 16'd1)) == '0);

endmodule

// File: rtl/block_transfer_sequencer.sv
// ---------------------------------------------------------------------------
// block_transfer_sequencer
// Walks the LDM/STM register list one beat at a time, presenting register
// number and word address to the load/store unit, and produces the base
// writeback value. Stalls the pipeline (busy) while an operation is live.
//   clk          in   1  core clock
//   reset        in   1  synchronous active-high reset
//   start        in   1  launch request, honoured only in IDLE
//   instruction  in  28  P=[24] U=[23] W=[21] L=[20] list=[15:0]
//   base         in  32  Rn value, sampled with start
//   ready        in   1  memory side accepts the current beat
//   busy         out  1  pipeline stall, XFER and DONE
//   valid        out  1  beat presented
//   reg_addr     out  4  register of the current beat
//   mem_addr     out 32  word address of the current beat
//   load         out  1  L for the operation
//   last         out  1  current beat is the final one
//   done         out  1  one-cycle end-of-operation pulse
//   wb_en        out  1  write wb_value to Rn (with done)
//   wb_value     out 32  base +/- 4*n
// ---------------------------------------------------------------------------
module block_transfer_sequencer
    import block_transfer_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [27:0]       instruction,
    input  logic [DATA_W-1:0] base,
    input  logic              ready,
    output logic              busy,
    output logic              valid,
    output logic [REG_W-1:0]  reg_addr,
    output logic [DATA_W-1:0] mem_addr,
    output logic              load,
    output logic              last,
    output logic              done,
    output logic              wb_en,
    output logic [DATA_W-1:0] wb_value
);

    seq_state_e        state_q;
    logic [LIST_W-1:0] list_q;
    logic              w_q;
    logic              busy_q;
    logic              valid_q;
    logic [REG_W-1:0]  reg_addr_q;
    logic [DATA_W-1:0] mem_addr_q;
    logic              load_q;
    logic              last_q;
    logic              done_q;
    logic              wb_en_q;
    logic [DATA_W-1:0] wb_value_q;

    logic [LIST_W-1:0] list_in_d;
    logic [LIST_W-1:0] list_rem_d;
    logic [LIST_W-1:0] find_vec_d;
    logic [REG_W-1:0]  find_idx_d;
    logic              find_one_d;
    logic [CNT_W-1:0]  count_d;
    logic [DATA_W-1:0] base_al_d;
    logic [DATA_W-1:0] span_d;
    logic [DATA_W-1:0] start_addr_d;
    logic [DATA_W-1:0] wb_value_d;
    xfer_mode_e        mode_d;
    logic              unused_inputs;

    assign list_in_d  = instruction[INSTR_LIST_LSB +: LIST_W];
    assign base_al_d  = {base[DATA_W-1:2], 2'b00};
    assign mode_d     = xfer_mode_e'({instruction[INSTR_P_BIT], instruction[INSTR_U_BIT]});

    // Fields decoded elsewhere (Rn, S bit, class bits) and the byte offset of base.
    assign unused_inputs = ^{instruction[27:25], instruction[22], instruction[19:16], base[1:0]};

    always_comb begin
        count_d = '0;
        for (int i = 0; i < LIST_W; i++) begin
            count_d = count_d + {{(CNT_W-1){1'b0}}, list_in_d[i]};
        end
    end

    assign span_d       = {{(DATA_W-CNT_W-2){1'b0}}, count_d, 2'b00};
    assign start_addr_d = first_addr(mode_d, base_al_d, span_d);
    assign wb_value_d   = wb_addr(instruction[INSTR_U_BIT], base_al_d, span_d);

    // The finder looks at the incoming list at launch, and at the list with
    // the current beat's bit removed during a transfer, so the next beat's
    // register and last flag are ready to register on acceptance.
    assign list_rem_d = list_q & ~(LIST_W'(1) << reg_addr_q);
    assign find_vec_d = (state_q == ST_IDLE) ? list_in_d : list_rem_d;

    priority_bit_find u_find (
        .vec_i (find_vec_d),
        .idx_o (find_idx_d),
        .one_o (find_one_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            list_q     <= '0;
            w_q        <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            reg_addr_q <= '0;
            mem_addr_q <= '0;
            load_q     <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_value_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q  <= 1'b0;
                    wb_en_q <= 1'b0;
                    if (start) begin
                        list_q     <= list_in_d;
                        w_q        <= instruction[INSTR_W_BIT];
                        load_q     <= instruction[INSTR_L_BIT];
                        wb_value_q <= wb_value_d;
                        mem_addr_q <= start_addr_d;
                        busy_q     <= 1'b1;
                        if (count_d == '0) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            wb_en_q <= instruction[INSTR_W_BIT];
                        end else begin
                            state_q    <= ST_XFER;
                            valid_q    <= 1'b1;
                            reg_addr_q <= find_idx_d;
                            last_q     <= find_one_d;
                        end
                    end
                end
                ST_XFER: begin
                    if (ready) begin
                        list_q     <= list_rem_d;
                        mem_addr_q <= mem_addr_q + 32'd4;
                        if (last_q) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            wb_en_q <= w_q;
                        end else begin
                            reg_addr_q <= find_idx_d;
                            last_q     <= find_one_d;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    wb_en_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    done_q  <= 1'b0;
                    wb_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign valid    = valid_q;
    assign reg_addr = reg_addr_q;
    assign mem_addr = mem_addr_q;
    assign load     = load_q;
    assign last     = last_q;
    assign done     = done_q;
    assign wb_en    = wb_en_q;
    assign wb_value = wb_value_q;

endmodule
